// File: rtl/gshare_predictor_v2.sv
`default_nettype none
// ============================================================================
// Module      : gshare_predictor_v2
// Description : Clocked gshare branch direction predictor. Speculatively
//               updates global history at predict time. Restores history on
//               mispredict. Overrides unconditional jumps to taken. Clears
//               its counter table with a sequential init walk, and keeps
//               lookup/mispredict performance counters.
// Revision    : 2.0 - parametrised, clocked successor to the fetch gshare
// ============================================================================
module gshare_predictor_v2 #(
  parameter int INDEX_BITS = 8,
  parameter int GHR_BITS   = 8,
  parameter int CNT_BITS   = 2,
  parameter int PERF_BITS  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  ready,
  input  logic                  pred_valid,
  input  logic [INDEX_BITS-1:0] pred_pc,
  input  logic [6:0]            pred_opcode,
  output logic                  pred_taken,
  output logic [GHR_BITS-1:0]   pred_ghr,
  input  logic                  upd_valid,
  input  logic [INDEX_BITS-1:0] upd_pc,
  input  logic [GHR_BITS-1:0]   upd_ghr,
  input  logic                  upd_is_cond,
  input  logic                  upd_taken,
  input  logic                  upd_mispredict,
  output logic [PERF_BITS-1:0]  perf_lookups,
  output logic [PERF_BITS-1:0]  perf_mispredicts
);

  localparam int                  c_depth    = 1 << INDEX_BITS;
  localparam logic [INDEX_BITS-1:0] c_last_ptr = '1;
  localparam logic [CNT_BITS-1:0] c_cnt_max  = '1;
  localparam logic [CNT_BITS-1:0] c_wnt      = {1'b0, {(CNT_BITS-1){1'b1}}};
  localparam logic [6:0]          c_op_br    = 7'b1100011;
  localparam logic [6:0]          c_op_jal   = 7'b1101111;
  localparam logic [6:0]          c_op_jalr  = 7'b1100111;

  // Reject parameter combinations the index/history logic cannot represent.
  generate
    if (GHR_BITS > INDEX_BITS) begin : g_chk_ghr_len
      $error("gshare_predictor_v2: GHR_BITS must not exceed INDEX_BITS");
    end
    if (GHR_BITS < 2) begin : g_chk_ghr_min
      $error("gshare_predictor_v2: GHR_BITS must be at least 2");
    end
    if ((CNT_BITS < 2) || (CNT_BITS > 4)) begin : g_chk_cnt
      $error("gshare_predictor_v2: CNT_BITS must be in 2..4");
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [INDEX_BITS-1:0] r_ptr;
  logic [GHR_BITS-1:0]   r_ghr;
  logic [CNT_BITS-1:0]   r_table [c_depth];
  logic [PERF_BITS-1:0]  r_perf_lookups;
  logic [PERF_BITS-1:0]  r_perf_mispredicts;

  logic                  w_run;
  logic [INDEX_BITS-1:0] w_pred_idx;
  logic [INDEX_BITS-1:0] w_upd_idx;
  logic                  w_is_branch;
  logic                  w_is_jump;
  logic                  w_pred_msb;
  logic                  w_lookup;
  logic                  w_table_we;
  logic                  w_recover;
  logic [CNT_BITS-1:0]   w_upd_cnt;
  logic [CNT_BITS-1:0]   w_upd_cnt_next;

  assign w_run       = (r_state == ST_RUN);
  assign w_pred_idx  = pred_pc ^ INDEX_BITS'(r_ghr);
  assign w_upd_idx   = upd_pc ^ INDEX_BITS'(upd_ghr);
  assign w_is_branch = (pred_opcode == c_op_br);
  assign w_is_jump   = (pred_opcode == c_op_jal) || (pred_opcode == c_op_jalr);
  assign w_pred_msb  = r_table[w_pred_idx][CNT_BITS-1];
  assign w_lookup    = w_run && pred_valid && w_is_branch;
  assign w_table_we  = w_run && upd_valid && upd_is_cond;
  assign w_recover   = w_run && upd_valid && upd_mispredict;
  assign w_upd_cnt   = r_table[w_upd_idx];

  // FSM state register: INIT after reset, RUN once the table walk finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_INIT;
    else        r_state <= w_state_next;
  end

  // FSM next state and status outputs.
  always_comb begin
    w_state_next = r_state;
    ready        = 1'b0;
    case (r_state)
      ST_INIT: if (r_ptr == c_last_ptr) w_state_next = ST_RUN;
      ST_RUN:  ready = 1'b1;
      default: w_state_next = ST_INIT;
    endcase
  end

  // Init pointer walks every table entry once per reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_ptr <= '0;
    else if (r_state == ST_INIT) r_ptr <= r_ptr + 1'b1;
  end

  // Saturating step of the counter being resolved.
  always_comb begin
    w_upd_cnt_next = w_upd_cnt;
    if (upd_taken) begin
      if (w_upd_cnt != c_cnt_max) w_upd_cnt_next = w_upd_cnt + 1'b1;
    end else begin
      if (w_upd_cnt != '0) w_upd_cnt_next = w_upd_cnt - 1'b1;
    end
  end

  // Counter table: init walk writes weakly-not-taken, RUN applies branch outcomes.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) r_table[r_ptr]     <= c_wnt;
    else if (w_table_we)    r_table[w_upd_idx] <= w_upd_cnt_next;
  end

  // Direction is combinational; the table read sees the pre-update value.
  assign pred_taken = w_run && pred_valid && (w_is_jump || (w_is_branch && w_pred_msb));
  assign pred_ghr   = r_ghr;

  // Global history: mispredict recovery overrides the speculative shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ghr <= '0;
    end else if (w_recover) begin
      r_ghr <= upd_is_cond ? {upd_ghr[GHR_BITS-2:0], upd_taken} : upd_ghr;
    end else if (w_lookup) begin
      r_ghr <= {r_ghr[GHR_BITS-2:0], pred_taken};
    end
  end

  // Performance counters, free-running and wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_lookups     <= '0;
      r_perf_mispredicts <= '0;
    end else begin
      if (w_lookup)  r_perf_lookups     <= r_perf_lookups + 1'b1;
      if (w_recover) r_perf_mispredicts <= r_perf_mispredicts + 1'b1;
    end
  end

  assign perf_lookups     = r_perf_lookups;
  assign perf_mispredicts = r_perf_mispredicts;

endmodule
`default_nettype wire

// File: tb/tb_gshare_predictor_v2.sv
`default_nettype none
// ============================================================================
// Module      : tb_gshare_predictor_v2
// Description : Self-checking bench for gshare_predictor_v2. A behavioural
//               model (integer table, integer history) tracks the expected
//               outputs every cycle; directed scenarios pin literal values.
// Revision    : 1.0
// ============================================================================
module tb_gshare_predictor_v2;

  localparam int IB    = 8;
  localparam int GB    = 8;
  localparam int CB    = 2;
  localparam int PB    = 32;
  localparam int DEPTH = 1 << IB;
  localparam int HMOD  = 1 << GB;
  localparam int CMAX  = (1 << CB) - 1;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          ready;
  logic          pred_valid;
  logic [IB-1:0] pred_pc;
  logic [6:0]    pred_opcode;
  logic          pred_taken;
  logic [GB-1:0] pred_ghr;
  logic          upd_valid;
  logic [IB-1:0] upd_pc;
  logic [GB-1:0] upd_ghr;
  logic          upd_is_cond;
  logic          upd_taken;
  logic          upd_mispredict;
  logic [PB-1:0] perf_lookups;
  logic [PB-1:0] perf_mispredicts;

  always #5 clk = ~clk;

  gshare_predictor_v2 #(
    .INDEX_BITS(IB), .GHR_BITS(GB), .CNT_BITS(CB), .PERF_BITS(PB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ready(ready),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_opcode(pred_opcode),
    .pred_taken(pred_taken), .pred_ghr(pred_ghr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
    .upd_is_cond(upd_is_cond), .upd_taken(upd_taken),
    .upd_mispredict(upd_mispredict),
    .perf_lookups(perf_lookups), .perf_mispredicts(perf_mispredicts)
  );

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  int     m_tbl [DEPTH];
  int     m_ghr;
  int     m_init;
  bit     m_ready;
  longint m_lk;
  longint m_mp;

  int exp_up [4] = '{1, 1, 1, 1};
  int exp_dn [4] = '{1, 0, 0, 0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int model_pred();
    if (!m_ready || !pred_valid) return 0;
    if (pred_opcode == OP_JAL || pred_opcode == OP_JALR) return 1;
    if (pred_opcode == OP_BR)
      return (m_tbl[(int'(pred_pc) ^ m_ghr) % DEPTH] >= (1 << (CB - 1))) ? 1 : 0;
    return 0;
  endfunction

  task automatic drive_idle();
    pred_valid = 1'b0; pred_pc = '0; pred_opcode = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_ghr = '0;
    upd_is_cond = 1'b0; upd_taken = 1'b0; upd_mispredict = 1'b0;
  endtask

  // Compare all outputs against the model, just after the falling edge.
  task automatic settle();
    #1;
    check("ready", 64'(ready), 64'(m_ready));
    check("pred_taken", 64'(pred_taken), 64'(model_pred()));
    check("pred_ghr", 64'(pred_ghr), 64'(m_ghr));
    check("perf_lookups", 64'(perf_lookups), 64'(m_lk));
    check("perf_mispredicts", 64'(perf_mispredicts), 64'(m_mp));
  endtask

  // Advance one clock and apply the architectural rules to the model.
  task automatic clock();
    int pt;
    bit lookup;
    int idx;
    pt     = model_pred();
    lookup = m_ready && pred_valid && (pred_opcode == OP_BR);
    @(posedge clk);
    if (rst_n) begin
      if (!m_ready) begin
        m_init++;
        if (m_init == DEPTH) begin
          m_ready = 1'b1;
          foreach (m_tbl[i]) m_tbl[i] = 1;
        end
      end else begin
        if (upd_valid && upd_is_cond) begin
          idx = (int'(upd_pc) ^ int'(upd_ghr)) % DEPTH;
          if (upd_taken) m_tbl[idx] = (m_tbl[idx] == CMAX) ? CMAX : m_tbl[idx] + 1;
          else           m_tbl[idx] = (m_tbl[idx] == 0) ? 0 : m_tbl[idx] - 1;
        end
        if (upd_valid && upd_mispredict) begin
          m_ghr = upd_is_cond ? (int'(upd_ghr) * 2 + int'(upd_taken)) % HMOD : int'(upd_ghr);
          m_mp  = (m_mp + 1) & 64'hFFFF_FFFF;
        end else if (lookup) begin
          m_ghr = (m_ghr * 2 + pt) % HMOD;
        end
        if (lookup) m_lk = (m_lk + 1) & 64'hFFFF_FFFF;
      end
    end
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    clock();
  endtask

  // Combinational lookup probe with no history shift at the edge.
  task automatic peek(input logic [IB-1:0] pc, output logic r);
    pred_valid = 1'b1; pred_opcode = OP_BR; pred_pc = pc;
    settle();
    r = pred_taken;
    pred_valid = 1'b0;
    clock();
  endtask

  // A real lookup with literal expectations; update inputs may be preset.
  task automatic lookup_lit(input logic [IB-1:0] pc, input logic [6:0] op,
                            input logic exp_pt, input logic [GB-1:0] exp_ghr,
                            input string name);
    pred_valid = 1'b1; pred_opcode = op; pred_pc = pc;
    settle();
    check({name, "_taken"}, 64'(pred_taken), 64'(exp_pt));
    check({name, "_ghr"}, 64'(pred_ghr), 64'(exp_ghr));
    clock();
    drive_idle();
  endtask

  task automatic junk_update();
    upd_valid = 1'b1; upd_is_cond = 1'b1;
    upd_pc = IB'($urandom); upd_ghr = GB'($urandom);
    upd_taken = 1'($urandom); upd_mispredict = 1'($urandom);
    pred_valid = 1'($urandom); pred_opcode = OP_BR; pred_pc = IB'($urandom);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    m_ready = 1'b0; m_init = 0; m_ghr = 0; m_lk = 0; m_mp = 0;
    drive_idle();
    pred_valid = 1'b1; pred_opcode = OP_JAL;
    settle();
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_pred_taken", 64'(pred_taken), 64'd0);
    check("rst_ghr", 64'(pred_ghr), 64'd0);
    check("rst_perf_lookups", 64'(perf_lookups), 64'd0);
    check("rst_perf_mispredicts", 64'(perf_mispredicts), 64'd0);
    repeat (3) clock();
    rst_n = 1'b1;
    drive_idle();
  endtask

  task automatic init_walk(input string name);
    for (int c = 0; c < DEPTH - 1; c++) begin
      junk_update();
      step();
    end
    check({name, "_not_ready_at_255"}, 64'(ready), 64'd0);
    junk_update();
    step();
    check({name, "_ready_at_256"}, 64'(ready), 64'd1);
    drive_idle();
  endtask

  initial begin
    logic r;
    drive_idle();
    foreach (m_tbl[i]) m_tbl[i] = 1;
    @(negedge clk);
    reset_pulse();

    // Init length, and updates during init are ignored
    init_walk("init");
    peek(8'h5C, r);
    check("first_branch_wnt", 64'(r), 64'd0);
    peek(8'hA7, r);
    check("second_branch_wnt", 64'(r), 64'd0);

    // Saturation at pc 0x10 with history 0
    for (int k = 0; k < 4; k++) begin
      upd_valid = 1'b1; upd_is_cond = 1'b1; upd_taken = 1'b1; upd_pc = 8'h10; upd_ghr = 8'h00;
      step();
      drive_idle();
      peek(8'h10, r);
      check("sat_up", 64'(r), 64'(exp_up[k]));
    end
    for (int k = 0; k < 4; k++) begin
      upd_valid = 1'b1; upd_is_cond = 1'b1; upd_taken = 1'b0; upd_pc = 8'h10; upd_ghr = 8'h00;
      step();
      drive_idle();
      peek(8'h10, r);
      check("sat_down", 64'(r), 64'(exp_dn[k]));
    end

    // Speculative history: predictions 0,0,1 then a jump
    upd_valid = 1'b1; upd_is_cond = 1'b1; upd_taken = 1'b1; upd_pc = 8'h20; upd_ghr = 8'h00;
    step();
    drive_idle();
    lookup_lit(8'h30, OP_BR, 1'b0, 8'h00, "spec0");
    lookup_lit(8'h31, OP_BR, 1'b0, 8'h00, "spec1");
    lookup_lit(8'h20, OP_BR, 1'b1, 8'h00, "spec2");
    lookup_lit(8'h55, OP_JAL, 1'b1, 8'h01, "spec_jal");
    settle();
    check("spec_ghr_after_jal", 64'(pred_ghr), 64'h01);
    check("spec_lookups", 64'(perf_lookups), 64'd3);
    clock();

    // Recovery: jump mispredict loads 0xA5, then a branch mispredict with a lookup
    upd_valid = 1'b1; upd_mispredict = 1'b1; upd_is_cond = 1'b0; upd_ghr = 8'hA5; upd_pc = 8'h07;
    step();
    drive_idle();
    settle();
    check("recov_setup_ghr", 64'(pred_ghr), 64'hA5);
    check("recov_setup_mp", 64'(perf_mispredicts), 64'd1);
    clock();
    upd_valid = 1'b1; upd_mispredict = 1'b1; upd_is_cond = 1'b1; upd_taken = 1'b1;
    upd_pc = 8'h44; upd_ghr = 8'h3C;
    lookup_lit(8'h12, OP_BR, 1'b0, 8'hA5, "recov_lookup");
    settle();
    check("recov_ghr", 64'(pred_ghr), 64'h79);
    check("recov_mp", 64'(perf_mispredicts), 64'd2);
    check("recov_lookups", 64'(perf_lookups), 64'd4);
    clock();

    // Read-before-write collision on idx 0x01
    upd_valid = 1'b1; upd_is_cond = 1'b1; upd_taken = 1'b1; upd_pc = 8'h01; upd_ghr = 8'h00;
    lookup_lit(8'h78, OP_BR, 1'b0, 8'h79, "collide");
    lookup_lit(8'hF3, OP_BR, 1'b1, 8'hF2, "collide_after");

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      pred_valid = ($urandom_range(0, 3) != 0);
      pred_pc    = IB'($urandom);
      case ($urandom_range(0, 5))
        0, 1, 2: pred_opcode = OP_BR;
        3:       pred_opcode = OP_JAL;
        4:       pred_opcode = OP_JALR;
        default: pred_opcode = 7'($urandom);
      endcase
      upd_valid      = ($urandom_range(0, 9) < 6);
      upd_pc         = ($urandom_range(0, 1) == 1) ? IB'($urandom_range(0, 15)) : IB'($urandom);
      upd_ghr        = ($urandom_range(0, 1) == 1) ? GB'(0) : GB'($urandom);
      upd_is_cond    = ($urandom_range(0, 3) != 0);
      upd_taken      = 1'($urandom);
      upd_mispredict = ($urandom_range(0, 4) == 0);
      step();
    end
    drive_idle();

    // Mid-run reset with nonzero history and counters
    upd_valid = 1'b1; upd_mispredict = 1'b1; upd_is_cond = 1'b0; upd_ghr = 8'h5A;
    step();
    drive_idle();
    settle();
    check("pre_reset_ghr", 64'(pred_ghr), 64'h5A);
    clock();
    reset_pulse();
    init_walk("reinit");
    for (int p = 0; p < DEPTH; p++) begin
      peek(IB'(p), r);
      check("wnt_after_reset", 64'(r), 64'd0);
    end
    upd_valid = 1'b1; upd_is_cond = 1'b1; upd_taken = 1'b1; upd_pc = 8'h10; upd_ghr = 8'h00;
    step();
    drive_idle();
    peek(8'h10, r);
    check("wnt_plus_one", 64'(r), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
